// File: rtl/llsc_reservation_ctrl_pkg.sv
// llsc_reservation_ctrl_pkg: shared constants, state encoding and default parameters for the LL/SC reservation block
// Contents: RstEnable/WriteEnable levels, llsc_state_e (IDLE/LINKED), default address/granule/timeout sizes
package llsc_reservation_ctrl_pkg;
   localparam logic RstEnable   = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_GRAN_LSB   = 2;
   localparam int DEF_TMO_W      = 10;
   localparam int DEF_TMO_CYCLES = 1023;
   typedef enum logic {
      IDLE   = 1'b0,
      LINKED = 1'b1
   } llsc_state_e;
endpackage

// File: rtl/llsc_reservation_ctrl_if.sv
// llsc_reservation_ctrl_if: MEM-stage and snoop signals between the pipeline and the LL/SC reservation controller
// master: pipeline side, drives flush/stall/op/snoop inputs and reads sc_ok_o, llbit_o, link_addr_o, expired_o
// slave:  reservation controller side
interface llsc_reservation_ctrl_if
   import llsc_reservation_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              flush;
   logic              stall_i;
   logic              mem_valid_i;
   logic              mem_ll_i;
   logic              mem_sc_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic              snoop_we_i;
   logic [ADDR_W-1:0] snoop_addr_i;
   logic              sc_ok_o;
   logic              llbit_o;
   logic [ADDR_W-1:0] link_addr_o;
   logic              expired_o;
   modport master (
      output flush, stall_i, mem_valid_i, mem_ll_i, mem_sc_i, mem_addr_i, snoop_we_i, snoop_addr_i,
      input  sc_ok_o, llbit_o, link_addr_o, expired_o
   );
   modport slave (
      input  flush, stall_i, mem_valid_i, mem_ll_i, mem_sc_i, mem_addr_i, snoop_we_i, snoop_addr_i,
      output sc_ok_o, llbit_o, link_addr_o, expired_o
   );
endinterface

// File: rtl/llsc_reservation_ctrl_timer.sv
// llsc_expiry_timer: saturating reservation age counter with clear, enable and terminal-count flag
// Ports: clk, rst (sync, active-high), clr (zero the count), en (count this cycle), tc (count is at TMO_CYCLES-1 while enabled)
module llsc_expiry_timer
   import llsc_reservation_ctrl_pkg::*;
#(
   parameter int TMO_W      = DEF_TMO_W,
   parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [TMO_W-1:0] count;
   always_ff @(posedge clk)
      count <= (rst == RstEnable || clr) ? '0 : (en && !(&count)) ? count + TMO_W'(1) : count;
   // TMO_CYCLES of 0 means the reservation never self-expires
   assign tc = en && (TMO_CYCLES != 0) && (count == TMO_W'(TMO_CYCLES - 1));
endmodule

// File: rtl/llsc_reservation_ctrl.sv
// llsc_reservation_ctrl: LL/SC reservation owner (link bit, link address, expiry) with snooping of external writes
// Ports: clk, rst (sync, active-high), bus (slave modport): MEM-stage LL/SC op and address, flush, stall,
//        snoop write strobe/address in; combinational sc_ok_o, registered llbit_o/link_addr_o, expired_o pulse out
module llsc_reservation_ctrl
   import llsc_reservation_ctrl_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int GRAN_LSB   = DEF_GRAN_LSB,
   parameter int TMO_W      = DEF_TMO_W,
   parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
   input logic clk,
   input logic rst,
   llsc_reservation_ctrl_if.slave bus
);
   function automatic logic same_gran(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      return (a >> GRAN_LSB) == (b >> GRAN_LSB);
   endfunction
   llsc_state_e       state, state_nxt;
   logic [ADDR_W-1:0] link_addr;
   logic              expired, llbit, op_fire, ll_fire, sc_fire, snoop_hit, tc, expire;
   assign llbit     = state == LINKED;
   assign op_fire   = bus.mem_valid_i && !bus.stall_i && !bus.flush;
   // LL together with SC is illegal and is handled as an SC
   assign ll_fire   = op_fire && bus.mem_ll_i && !bus.mem_sc_i;
   assign sc_fire   = op_fire && bus.mem_sc_i;
   assign snoop_hit = bus.snoop_we_i == WriteEnable && llbit && same_gran(bus.snoop_addr_i, link_addr);
   // expiry only wins when nothing of higher priority touches the reservation this cycle
   assign expire    = tc && !bus.flush && !ll_fire && !sc_fire && !snoop_hit;
   always_comb
      state_nxt = bus.flush ? IDLE : ll_fire ? LINKED : (sc_fire || snoop_hit || expire) ? IDLE : state;
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state     <= IDLE;
         link_addr <= '0;
         expired   <= 1'b0;
      end else begin
         state     <= state_nxt;
         link_addr <= ll_fire ? (bus.mem_addr_i >> GRAN_LSB) << GRAN_LSB : link_addr;
         expired   <= expire;
      end
   end
   // the timer keeps running through stalls; any (re)link or drop to IDLE restarts it from zero
   llsc_expiry_timer #(.TMO_W(TMO_W), .TMO_CYCLES(TMO_CYCLES)) u_timer (
      .clk(clk),
      .rst(rst),
      .clr(ll_fire || state_nxt == IDLE),
      .en (llbit),
      .tc (tc)
   );
   assign bus.sc_ok_o     = bus.mem_valid_i && bus.mem_sc_i && llbit && same_gran(bus.mem_addr_i, link_addr)
                            && !snoop_hit && !bus.flush;
   assign bus.llbit_o     = llbit;
   assign bus.link_addr_o = link_addr;
   assign bus.expired_o   = expired;
   ll_sc_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(bus.mem_valid_i && bus.mem_ll_i && bus.mem_sc_i));
endmodule

// File: tb/tb_llsc_reservation_ctrl.sv
// tb_llsc_reservation_ctrl: directed and randomized checks of llsc_reservation_ctrl against a cycle-numbered reference model
module tb_llsc_reservation_ctrl;
   localparam int AW  = 32;
   localparam int GL  = 2;
   localparam int TMO = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   llsc_reservation_ctrl_if #(.ADDR_W(AW)) bus ();
   llsc_reservation_ctrl #(.ADDR_W(AW), .GRAN_LSB(GL), .TMO_W(10), .TMO_CYCLES(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   // model: reservation is a flag plus aligned address plus the edge number at which it was linked
   bit          m_linked = 1'b0;
   logic [AW-1:0] m_addr = '0;
   bit          m_exp = 1'b0;
   int          m_link_cyc = 0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   function automatic bit same_gran(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return (a / (1 << GL)) == (b / (1 << GL));
   endfunction
   task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask
   task automatic set_in(input bit v, input bit ll, input bit sc, input logic [AW-1:0] a,
                         input bit swe, input logic [AW-1:0] sa, input bit st, input bit fl);
      bus.mem_valid_i  = v;
      bus.mem_ll_i     = ll;
      bus.mem_sc_i     = sc;
      bus.mem_addr_i   = a;
      bus.snoop_we_i   = swe;
      bus.snoop_addr_i = sa;
      bus.stall_i      = st;
      bus.flush        = fl;
   endtask
   task automatic idle();
      set_in(0, 0, 0, '0, 0, '0, 0, 0);
   endtask
   // compares all outputs before the edge, then advances the model across the edge; returns at edge+1
   task automatic cycle();
      bit v, ll, sc, fl, st, swe, r, hit, fire;
      logic [AW-1:0] a, sa;
      v = bus.mem_valid_i; ll = bus.mem_ll_i; sc = bus.mem_sc_i; a = bus.mem_addr_i;
      swe = bus.snoop_we_i; sa = bus.snoop_addr_i; st = bus.stall_i; fl = bus.flush; r = rst;
      hit  = swe && m_linked && same_gran(sa, m_addr);
      fire = v && !st && !fl;
      @(negedge clk);
      if (!r) check("sc_ok", bus.sc_ok_o, v && sc && m_linked && same_gran(a, m_addr) && !hit && !fl);
      check("llbit", bus.llbit_o, m_linked);
      check("link_addr", bus.link_addr_o, m_addr);
      check("expired", bus.expired_o, m_exp);
      @(posedge clk);
      cyc++;
      m_exp = 1'b0;
      if (r) begin
         m_linked = 1'b0;
         m_addr   = '0;
      end else if (fl) m_linked = 1'b0;
      else if (fire && ll && !sc) begin
         m_linked   = 1'b1;
         m_addr     = a - (a % (1 << GL));
         m_link_cyc = cyc;
      end else if (fire && sc) m_linked = 1'b0;
      else if (hit) m_linked = 1'b0;
      else if (m_linked && cyc - m_link_cyc == TMO) begin
         m_linked = 1'b0;
         m_exp    = 1'b1;
      end
      #1;
   endtask
   initial begin
      idle();
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      check("rst_llbit", bus.llbit_o, 0);
      check("rst_link_addr", bus.link_addr_o, 0);
      check("rst_expired", bus.expired_o, 0);
      // 1: LL, 3 idle, SC same address
      set_in(1, 1, 0, 32'h1004, 0, '0, 0, 0);
      cycle();
      check("t1_llbit", bus.llbit_o, 1);
      check("t1_link_addr", bus.link_addr_o, 32'h1004);
      idle();
      repeat (3) cycle();
      set_in(1, 0, 1, 32'h1004, 0, '0, 0, 0);
      #1 check("t1_sc_ok", bus.sc_ok_o, 1);
      cycle();
      check("t1_llbit_after", bus.llbit_o, 0);
      // 2: SC to other granule fails and kills the link
      set_in(1, 1, 0, 32'h1000, 0, '0, 0, 0);
      cycle();
      set_in(1, 0, 1, 32'h1008, 0, '0, 0, 0);
      #1 check("t2_sc_ok_diff", bus.sc_ok_o, 0);
      cycle();
      check("t2_llbit", bus.llbit_o, 0);
      set_in(1, 0, 1, 32'h1000, 0, '0, 0, 0);
      #1 check("t2_sc_ok_second", bus.sc_ok_o, 0);
      cycle();
      // 3: snoop same granule kills, neighbouring granule does not
      set_in(1, 1, 0, 32'h2000, 0, '0, 0, 0);
      cycle();
      set_in(0, 0, 0, '0, 1, 32'h2002, 0, 0);
      cycle();
      check("t3_llbit_hit", bus.llbit_o, 0);
      set_in(1, 0, 1, 32'h2000, 0, '0, 0, 0);
      #1 check("t3_sc_ok_hit", bus.sc_ok_o, 0);
      cycle();
      set_in(1, 1, 0, 32'h2000, 0, '0, 0, 0);
      cycle();
      set_in(0, 0, 0, '0, 1, 32'h2004, 0, 0);
      cycle();
      check("t3_llbit_miss", bus.llbit_o, 1);
      set_in(1, 0, 1, 32'h2000, 0, '0, 0, 0);
      #1 check("t3_sc_ok_miss", bus.sc_ok_o, 1);
      cycle();
      // 4: stalled SC, snoop hit in stall cycle 2
      set_in(1, 1, 0, 32'h3000, 0, '0, 0, 0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 1, 32'h3000, i == 2, 32'h3000, 1, 0);
         #1 check($sformatf("t4_stall%0d_sc_ok", i), bus.sc_ok_o, i < 2);
         cycle();
      end
      set_in(1, 0, 1, 32'h3000, 0, '0, 0, 0);
      #1 check("t4_fired_sc_ok", bus.sc_ok_o, 0);
      cycle();
      // 5: self-expiry 8 cycles after the LL edge, then re-arm
      for (int p = 0; p < 2; p++) begin
         set_in(1, 1, 0, 32'h4000, 0, '0, 0, 0);
         cycle();
         idle();
         for (int k = 1; k <= TMO; k++) begin
            cycle();
            check($sformatf("t5_p%0d_expired_%0d", p, k), bus.expired_o, k == TMO);
            check($sformatf("t5_p%0d_llbit_%0d", p, k), bus.llbit_o, k != TMO);
         end
         cycle();
         check($sformatf("t5_p%0d_pulse_end", p), bus.expired_o, 0);
         set_in(1, 0, 1, 32'h4000, 0, '0, 0, 0);
         #1 check($sformatf("t5_p%0d_sc_ok", p), bus.sc_ok_o, 0);
         cycle();
      end
      // 6: flush with SC, then reset while linked
      set_in(1, 1, 0, 32'h5000, 0, '0, 0, 0);
      cycle();
      set_in(1, 0, 1, 32'h5000, 0, '0, 0, 1);
      #1 check("t6_flush_sc_ok", bus.sc_ok_o, 0);
      cycle();
      check("t6_flush_llbit", bus.llbit_o, 0);
      set_in(1, 1, 0, 32'h6000, 0, '0, 0, 0);
      cycle();
      idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_rst_llbit", bus.llbit_o, 0);
      check("t6_rst_link_addr", bus.link_addr_o, 0);
      // randomized traffic over a few colliding granules
      for (int i = 0; i < 2000; i++) begin
         int op;
         op = $urandom_range(0, 3);
         set_in($urandom_range(0, 1), op == 1, op == 2, 32'h100 | $urandom_range(0, 15),
                $urandom_range(0, 9) < 3, 32'h100 | $urandom_range(0, 15),
                $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
         rst = $urandom_range(0, 99) == 0;
         cycle();
      end
      rst = 1'b0;
      idle();
      cycle();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/llsc_reservation_ctrl.md
Name: llsc_reservation_ctrl

Overview:
Controls the LL/SC reservation for the CPU core. It owns the link bit, the link address and an expiry timer. LL/SC operations in the MEM stage update the reservation, and external bus-master writes are snooped against it. Each SC gets a single-cycle pass/fail verdict, which the MEM stage uses to gate the store and to write 1/0 into rt.

Parameters:
ADDR_W, 32, physical address width
GRAN_LSB, 2, reservation granule: addresses compared on bits [ADDR_W-1:GRAN_LSB]
TMO_W, 10, expiry counter width
TMO_CYCLES, 1023, cycles after LL before the reservation self-expires; 0 disables expiry

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  exception/ERET pipeline flush
stall_i  in  1  MEM stage stalled; hold all state except the timer
mem_valid_i  in  1  MEM stage holds a valid instruction
mem_ll_i  in  1  MEM instruction is LL
mem_sc_i  in  1  MEM instruction is SC
mem_addr_i  in  ADDR_W  effective address of LL/SC
snoop_we_i  in  1  another master commits a write this cycle
snoop_addr_i  in  ADDR_W  address of that write
sc_ok_o  out  1  combinational: current SC succeeds
llbit_o  out  1  registered link bit, also readable via CP0
link_addr_o  out  ADDR_W  registered link address (granule-aligned, low bits zero)
expired_o  out  1  one-cycle pulse when the timer expires an active reservation

Behaviour:
- Reset is synchronous, active-high (rst), on clock clk.
  - Reset values: llbit_o=0, link_addr_o=0, timer=0, expired_o=0, state=IDLE.
- State machine has two states, IDLE and LINKED; llbit_o=1 exactly in LINKED.
- Definitions:
  - op_fire = mem_valid_i & ~stall_i & ~flush.
  - gran(x) = x[ADDR_W-1:GRAN_LSB].
  - snoop_hit = snoop_we_i & llbit_o & gran(snoop_addr_i)==gran(link_addr_o).
- sc_ok_o = mem_valid_i & mem_sc_i & llbit_o & gran(mem_addr_i)==gran(link_addr_o) & ~snoop_hit & ~flush.
  - It is valid in the same cycle the SC is in MEM. There is no registered latency.
- Update priority, evaluated each posedge:
  1. rst forces the reset values.
  2. flush forces IDLE and zeroes the timer. link_addr_o is held, and the in-flight op is ignored.
  3. op_fire & mem_ll_i: go to LINKED, link_addr_o <= gran-aligned mem_addr_i, timer <= 0. A same-cycle snoop_hit is applied before this, so LL still links.
  4. op_fire & mem_sc_i: go to IDLE regardless of outcome. The timer is cleared.
  5. snoop_hit: go to IDLE.
  6. Timer expiry: if TMO_CYCLES != 0, LINKED and timer==TMO_CYCLES-1, then go to IDLE and pulse expired_o for one cycle.
  7. Otherwise in LINKED, the timer increments every cycle, including stall cycles.
- mem_ll_i and mem_sc_i both asserted is illegal. Treat it as SC (rule 4); a simulation assertion flags it.
- A snoop with llbit_o=0 has no effect.
- A stalled SC keeps re-evaluating sc_ok_o each cycle. The reservation clears only when the SC fires.
- While stalled, the state is frozen, but a snoop_hit or expiry during the stall still clears it. The SC then sees failure.
- The timer saturates and never wraps while in IDLE (held at 0).
- Reset mid-reservation clears the reservation, and the same cycle's sc_ok_o is don't-care.

Decomposition:
- The shared defines header gets RstEnable/WriteEnable-style constants, LLSC state encodings (IDLE=1'b0, LINKED=1'b1) and the default granule/timeout constants.
- One natural sub-module is llsc_expiry_timer: a counter with clear, enable, and a terminal-count pulse.
- The comparator and state machine stay in the top module.

Test Plan:
1. LL at 0x0000_1004, then after 3 idle cycles SC at 0x0000_1004 -> sc_ok_o=1 in the SC cycle; llbit_o goes 1 then 0 after the SC fires; link_addr_o=0x0000_1004.
2. LL at 0x1000, then SC at 0x1008 -> sc_ok_o=0; llbit_o=0 after the SC fires. A second SC to 0x1000 also gives sc_ok_o=0.
3. LL at 0x2000, snoop_we_i with snoop_addr_i=0x2002 (same granule), then SC at 0x2000 -> llbit_o=0 the cycle after the snoop; sc_ok_o=0. Repeat with snoop at 0x2004 -> sc_ok_o=1.
4. SC in MEM held by stall_i for 4 cycles, with snoop_hit in stall cycle 2 -> sc_ok_o=1 in stall cycles 0–1 and 0 from cycle 2 on; the final fired SC fails.
5. TMO_CYCLES=8: LL, then idle -> expired_o pulses exactly 8 cycles after the LL edge and llbit_o drops; a later SC fails. LL again re-arms with the timer at 0.
6. LL fired, then flush asserted alongside an SC in MEM -> sc_ok_o=0, llbit_o=0. Separately, assert rst while LINKED -> llbit_o=0 and link_addr_o=0 the next cycle.
